// File: rtl/panel_control.sv
// ---------------------------------------------------------------------------
// panel_control
//   Front-panel controller for a washing machine. It debounces four raw
//   push-buttons, turns each accepted press into a single-cycle pulse, and
//   runs the power / run-state / wash-mode / water-level registers. A beep
//   sequencer sounds the buzzer when a program completes and then powers
//   the machine off by itself.
//
// Parameters
//   DEB_N   clk cycles a synchronized key must hold a new level before it
//           is accepted
//   HALF_S  clk cycles per beep phase (buzzer on, or buzzer off)
//   BEEPS   number of on/off beep periods before the automatic power-off
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   power_key      raw push-button, active-high
//   start_key      raw push-button, active-high
//   model_key      raw push-button, active-high
//   water_key      raw push-button, active-high
//   finish         program-complete level from the time controller
//   power_light    machine powered
//   run_state      00 idle, 01 running, 10 paused
//   current_model  wash mode 0..5
//   current_water  water level 1..5
//   buzzer         completion beep drive
// ---------------------------------------------------------------------------
module panel_control #(
    parameter int DEB_N  = 1_000_000,
    parameter int HALF_S = 50_000_000,
    parameter int BEEPS  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power_key,
    input  logic       start_key,
    input  logic       model_key,
    input  logic       water_key,
    input  logic       finish,
    output logic       power_light,
    output logic [1:0] run_state,
    output logic [2:0] current_model,
    output logic [2:0] current_water,
    output logic       buzzer
);

    localparam int DEB_CW  = (DEB_N  > 1) ? $clog2(DEB_N + 1)  : 1;
    localparam int HALF_CW = (HALF_S > 1) ? $clog2(HALF_S + 1) : 1;
    localparam int PER_CW  = (BEEPS  > 1) ? $clog2(BEEPS + 1)  : 1;

    localparam logic [DEB_CW-1:0]  DEB_LAST  = DEB_CW'(DEB_N - 1);
    localparam logic [HALF_CW-1:0] HALF_LAST = HALF_CW'(HALF_S - 1);
    localparam logic [PER_CW-1:0]  PER_LAST  = PER_CW'(BEEPS - 1);

    localparam logic [1:0] RS_IDLE  = 2'b00;
    localparam logic [1:0] RS_RUN   = 2'b01;
    localparam logic [1:0] RS_PAUSE = 2'b10;

    localparam logic [2:0] MODEL_DEFAULT = 3'd0;
    localparam logic [2:0] WATER_DEFAULT = 3'd2;

    typedef enum logic [1:0] {
        BEEP_IDLE,
        BEEP_ON,
        BEEP_OFF,
        BEEP_DONE
    } beep_state_t;

    // Key index: 0 power, 1 start, 2 model, 3 water
    logic [3:0] raw_keys;
    logic [3:0] press;

    assign raw_keys = {water_key, model_key, start_key, power_key};

    // -----------------------------------------------------------------------
    // Per-key synchronizer + debounce. The counter runs only while the
    // synchronized input disagrees with the accepted level; any agreeing
    // sample restarts it, so the level moves only after DEB_N consecutive
    // disagreeing samples. The press pulse fires on the same cycle the level
    // is accepted as 1, so the panel registers update on that same edge.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            logic              sync1_q, sync2_q;
            logic              level_q, level_d;
            logic [DEB_CW-1:0] cnt_q, cnt_d;

            always_comb begin
                level_d = level_q;
                cnt_d   = '0;
                if (sync2_q != level_q) begin
                    if (cnt_q == DEB_LAST) begin
                        level_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Only a 0->1 acceptance produces a pulse; a release never does.
            assign press[gi] = (sync2_q != level_q) && (cnt_q == DEB_LAST) && sync2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= raw_keys[gi];
                    sync2_q <= sync1_q;
                    level_q <= level_d;
                    cnt_q   <= cnt_d;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Panel registers and beep sequencer
    // -----------------------------------------------------------------------
    logic               power_q, power_d;
    logic [1:0]         run_state_q, run_state_d;
    logic [2:0]         model_q, model_d;
    logic [2:0]         water_q, water_d;
    logic               buzzer_q, buzzer_d;
    beep_state_t        beep_state_q, beep_state_d;
    logic [HALF_CW-1:0] beep_cnt_q, beep_cnt_d;
    logic [PER_CW-1:0]  period_q, period_d;
    logic               auto_off;

    always_comb begin
        power_d      = power_q;
        run_state_d  = run_state_q;
        model_d      = model_q;
        water_d      = water_q;
        buzzer_d     = buzzer_q;
        beep_state_d = beep_state_q;
        beep_cnt_d   = beep_cnt_q;
        period_d     = period_q;
        auto_off     = 1'b0;

        case (beep_state_q)
            BEEP_IDLE: begin
                if (finish && power_q) begin
                    beep_state_d = BEEP_ON;
                    beep_cnt_d   = '0;
                    period_d     = '0;
                    buzzer_d     = 1'b1;
                end
            end
            BEEP_ON: begin
                if (beep_cnt_q == HALF_LAST) begin
                    beep_state_d = BEEP_OFF;
                    beep_cnt_d   = '0;
                    buzzer_d     = 1'b0;
                end else begin
                    beep_cnt_d = beep_cnt_q + 1'b1;
                end
            end
            BEEP_OFF: begin
                if (beep_cnt_q == HALF_LAST) begin
                    beep_cnt_d = '0;
                    period_d   = period_q + 1'b1;
                    if (period_q == PER_LAST) begin
                        beep_state_d = BEEP_DONE;
                    end else begin
                        beep_state_d = BEEP_ON;
                        buzzer_d     = 1'b1;
                    end
                end else begin
                    beep_cnt_d = beep_cnt_q + 1'b1;
                end
            end
            BEEP_DONE: begin
                auto_off = 1'b1;
            end
            default: begin
                beep_state_d = BEEP_IDLE;
            end
        endcase

        // Power changes (key toggle or automatic off) override everything
        // else and bring every panel register back to its power-on value.
        if (press[0] || auto_off) begin
            power_d      = press[0] ? ~power_q : 1'b0;
            run_state_d  = RS_IDLE;
            model_d      = MODEL_DEFAULT;
            water_d      = WATER_DEFAULT;
            buzzer_d     = 1'b0;
            beep_state_d = BEEP_IDLE;
            beep_cnt_d   = '0;
            period_d     = '0;
        end else if (power_q) begin
            if (press[1] && !finish) begin
                case (run_state_q)
                    RS_IDLE:  run_state_d = RS_RUN;
                    RS_RUN:   run_state_d = RS_PAUSE;
                    RS_PAUSE: run_state_d = RS_RUN;
                    default:  run_state_d = RS_IDLE;
                endcase
            end
            // Mode and level are judged on the pre-start state so a start
            // arriving alongside them in idle still lets them apply.
            if (run_state_q == RS_IDLE) begin
                if (press[2]) begin
                    model_d = (model_q == 3'd5) ? 3'd0 : model_q + 3'd1;
                end
                if (press[3]) begin
                    water_d = (water_q == 3'd5) ? 3'd1 : water_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            power_q      <= 1'b0;
            run_state_q  <= RS_IDLE;
            model_q      <= MODEL_DEFAULT;
            water_q      <= WATER_DEFAULT;
            buzzer_q     <= 1'b0;
            beep_state_q <= BEEP_IDLE;
            beep_cnt_q   <= '0;
            period_q     <= '0;
        end else begin
            power_q      <= power_d;
            run_state_q  <= run_state_d;
            model_q      <= model_d;
            water_q      <= water_d;
            buzzer_q     <= buzzer_d;
            beep_state_q <= beep_state_d;
            beep_cnt_q   <= beep_cnt_d;
            period_q     <= period_d;
        end
    end

    assign power_light   = power_q;
    assign run_state     = run_state_q;
    assign current_model = model_q;
    assign current_water = water_q;
    assign buzzer        = buzzer_q;

endmodule
